systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_seq_ctrl_if.sv | 31 +++
 rtl/systolic_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Handshake/bus bundle between a job issuer and the systolic array sequencer.
// master = job issuer, slave = sequencer.
interface systolic_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int AW = 8
);
  logic                 start;
  logic                 abort;
  logic [AW-1:0]        num_rows;
  logic                 busy;
  logic                 done;
  logic [$clog2(N)-1:0] w_rd_addr;
  logic [N-1:0]         wt_row_we;
  logic                 x_rd_en;
  logic [AW-1:0]        x_rd_addr;
  logic [N-1:0]         data_valid;
  logic                 can_use;
  logic [2:0]           state_o;

  modport master (
    output start, abort, num_rows,
    input  busy, done, w_rd_addr, wt_row_we, x_rd_en, x_rd_addr,
           data_valid, can_use, state_o
  );

  modport slave (
    input  start, abort, num_rows,
    output busy, done, w_rd_addr, wt_row_we, x_rd_en, x_rd_addr,
           data_valid, can_use, state_o
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN weight-stationary systolic array: loads weights row by
// row, streams M skewed X vectors, drains the pipeline and pulses done.
module systolic_seq_ctrl #(
  parameter int N  = 4,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int WA = $clog2(N);
  // Wide enough for M+N-1 with M=2^AW-1 and N up to 16.
  localparam int CW = AW + 6;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] FEED   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] m_lat, m_n;

  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [WA-1:0] w_rd_addr_q, w_rd_addr_n;
  logic [N-1:0]  wt_row_we_q, wt_row_we_n;
  logic          x_rd_en_q, x_rd_en_n;
  logic [AW-1:0] x_rd_addr_q, x_rd_addr_n;
  logic [N-1:0]  data_valid_q, data_valid_n;
  logic          can_use_q, can_use_n;
  logic [CW-1:0] m_ext;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    m_n     = m_lat;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_n = '0;
          if (bus.num_rows != '0) begin
            m_n     = bus.num_rows;
            state_n = LOAD_W;
          end else begin
            state_n = DONE;
          end
        end
      end
      LOAD_W: begin
        if (cnt == CW'(N - 1)) begin
          state_n = FEED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FEED: begin
        if (cnt == CW'(m_lat) + CW'(N - 1)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == CW'(N)) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned
  // with the state they describe.
  always_comb begin
    m_ext        = CW'(m_n);
    busy_n       = (state_n != IDLE);
    done_n       = (state_n == DONE);
    w_rd_addr_n  = '0;
    wt_row_we_n  = '0;
    x_rd_en_n    = 1'b0;
    x_rd_addr_n  = '0;
    data_valid_n = '0;
    case (state_n)
      LOAD_W: begin
        w_rd_addr_n = cnt_n[WA-1:0];
        wt_row_we_n = {{(N-1){1'b0}}, 1'b1} << cnt_n[WA-1:0];
      end
      FEED: begin
        if (cnt_n < m_ext) begin
          x_rd_en_n   = 1'b1;
          x_rd_addr_n = cnt_n[AW-1:0];
        end else begin
          x_rd_addr_n = x_rd_addr_q;
        end
        // Row i sees data one cycle after the read plus i cycles of skew.
        for (int i = 0; i < N; i++) begin
          data_valid_n[i] = (cnt_n > CW'(i)) && ((cnt_n - CW'(i + 1)) < m_ext);
        end
      end
      default: ;
    endcase
    can_use_n = data_valid_n[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      m_lat        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_rd_addr_q  <= '0;
      wt_row_we_q  <= '0;
      x_rd_en_q    <= 1'b0;
      x_rd_addr_q  <= '0;
      data_valid_q <= '0;
      can_use_q    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      m_lat        <= m_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      w_rd_addr_q  <= w_rd_addr_n;
      wt_row_we_q  <= wt_row_we_n;
      x_rd_en_q    <= x_rd_en_n;
      x_rd_addr_q  <= x_rd_addr_n;
      data_valid_q <= data_valid_n;
      can_use_q    <= can_use_n;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.w_rd_addr  = w_rd_addr_q;
  assign bus.wt_row_we  = wt_row_we_q;
  assign bus.x_rd_en    = x_rd_en_q;
  assign bus.x_rd_addr  = x_rd_addr_q;
  assign bus.data_valid = data_valid_q;
  assign bus.can_use    = can_use_q;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed self-checking bench for systolic_seq_ctrl (N=4, AW=8); expected
// outputs come from cycle-number formulas relative to the start pulse.
module tb_systolic_seq_ctrl;
  localparam int N  = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_seq_ctrl_if #(.N(N), .AW(AW)) bus ();

  systolic_seq_ctrl #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [AW-1:0] nr);
    bus.start    = s;
    bus.abort    = a;
    bus.num_rows = nr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {state_o, busy, done, w_rd_addr, wt_row_we, x_rd_en, x_rd_addr, data_valid, can_use}
  function automatic logic [31:0] outVec();
    return 32'({bus.state_o, bus.busy, bus.done, bus.w_rd_addr, bus.wt_row_we,
                bus.x_rd_en, bus.x_rd_addr, bus.data_valid, bus.can_use});
  endfunction

  // Expected outputs in cycle t when start was sampled at the end of cycle 0.
  function automatic logic [31:0] expVec(int t, int m, int abortAt);
    int         tDone;
    logic [2:0] st;
    logic       busy, done, xe;
    logic [1:0] wa;
    logic [3:0] we, dv;
    logic [7:0] xa;
    st = 3'd0; busy = 1'b0; done = 1'b0; xe = 1'b0;
    wa = '0; we = '0; dv = '0; xa = '0;
    tDone = (m == 0) ? 1 : 3 * N + m + 2;
    if (abortAt >= 0 && t > abortAt) return 32'd0;
    if (t == tDone) begin
      st = 3'd4; busy = 1'b1; done = 1'b1;
    end else if (m > 0 && t >= 1 && t <= N) begin
      st = 3'd1; busy = 1'b1;
      wa = 2'(t - 1);
      we = 4'(1 << (t - 1));
    end else if (m > 0 && t > N && t <= 2 * N + m) begin
      st = 3'd2; busy = 1'b1;
      if (t <= N + m) begin
        xe = 1'b1;
        xa = 8'(t - N - 1);
      end else begin
        xa = 8'(m - 1);
      end
      for (int i = 0; i < N; i++) dv[i] = (t >= N + 2 + i) && (t <= N + 1 + i + m);
    end else if (m > 0 && t > 2 * N + m && t < tDone) begin
      st = 3'd3; busy = 1'b1;
    end
    return 32'({st, busy, done, wa, we, xe, xa, dv, dv[0]});
  endfunction

  task automatic runJob(input int m, input int restartAt, input int abortAt,
                        input string name);
    int tEnd;
    tEnd = ((m == 0) ? 1 : 3 * N + m + 2) + 2;
    applyStimulus(1'b1, 1'b0, AW'(m));
    tick();
    applyStimulus(1'b0, 1'b0, AW'(m));
    for (int t = 1; t <= tEnd; t++) begin
      checkOutput($sformatf("%s t=%0d", name, t), outVec(), expVec(t, m, abortAt));
      if (t == restartAt) applyStimulus(1'b1, 1'b0, AW'(9));
      if (t == abortAt)   applyStimulus(1'b0, 1'b1, AW'(m));
      tick();
      applyStimulus(1'b0, 1'b0, AW'(m));
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset", outVec(), 32'd0);
    #2 rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", outVec(), 32'd0);

    runJob(3, -1, -1, "m3");
    runJob(0, -1, -1, "m0");
    runJob(3, 6, -1, "restart_in_feed");
    runJob(3, -1, 7, "abort_c7");
    runJob(3, -1, -1, "after_abort");

    applyStimulus(1'b1, 1'b1, AW'(3));
    tick();
    applyStimulus(1'b0, 1'b0, AW'(3));
    checkOutput("start_abort_idle", outVec(), 32'd0);
    tick();
    checkOutput("start_abort_idle2", outVec(), 32'd0);
    applyStimulus(1'b0, 1'b1, AW'(3));
    tick();
    applyStimulus(1'b0, 1'b0, AW'(3));
    checkOutput("abort_in_idle", outVec(), 32'd0);

    // Asynchronous reset in the middle of LOAD_W, between clock edges.
    applyStimulus(1'b1, 1'b0, AW'(3));
    tick();
    applyStimulus(1'b0, 1'b0, AW'(3));
    tick();
    checkOutput("loadw_pre_reset", outVec(), expVec(2, 3, -1));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", outVec(), 32'd0);
    checkOutput("async_reset_state", 32'(bus.state_o), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    checkOutput("idle_after_async_reset", outVec(), 32'd0);
    runJob(3, -1, -1, "after_reset");

    runJob(255, -1, -1, "m255");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
